im2col_window_scheduler: RTL and testbench
==========================================

Name: im2col_window_scheduler

Overview:
- Upstream command generator for the im2col address stage.
- Walks the kernel-window origin across one stored image tile (columns spread over NUM_RAM banks, rows over RAM_DEPTH words), stepping by a configurable stride.
- Issues one command per window (kerWidth, startAddrX, startAddrY, dv) and waits for the im2col done before issuing the next.
- Reports frame completion and a window count to the tile controller.

Parameters:
- NUM_RAM, 8, number of RAM banks = image columns; XW = $clog2(NUM_RAM)
- RAM_DEPTH, 32, words per bank = image rows; YW = $clog2(RAM_DEPTH)
- MAX_KER, 4, largest kernel width; KW = $clog2(MAX_KER)
- TIMEOUT_CYC, 255, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle frame start request
- imgWidth  in  XW+1  image columns, legal 1..NUM_RAM
- imgHeight  in  YW+1  image rows, legal 1..RAM_DEPTH
- kerWidth  in  KW  kernel width minus 1 (0 means 1x1)
- stride  in  KW  window step; 0 treated as 1
- im2colDone  in  1  one-cycle pulse from im2col: current window finished
- cmdKerWidth  out  KW  latched kerWidth
- cmdStartX  out  XW  window origin column
- cmdStartY  out  YW  window origin row
- cmdDv  out  1  one-cycle command valid
- busy  out  1  high from accepted start until frameDone
- frameDone  out  1  one-cycle pulse after the last window completes
- cfgErr  out  1  one-cycle pulse when start is rejected
- winCnt  out  XW+YW+1  windows issued in the current/last frame
- timeoutErr  out  1  sticky watchdog flag (tied 0 without the macro)

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0, including winCnt and timeoutErr. Internal counters clear. Reset in any state aborts the frame, and outputs are 0 on the cycle after rst.
- Notation: K = kerWidth+1, S = max(stride,1), W = imgWidth, H = imgHeight.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start with K>W, K>H, W=0 or H=0: cfgErr=1 for the next cycle; remain in IDLE; no cmdDv.
  - Otherwise, on start: latch K, S, W, H; x=0, y=0; winCnt=0; busy=1; go to ISSUE.
- ISSUE: cmdDv=1 for exactly one cycle with cmdStartX=x, cmdStartY=y. winCnt increments on this cycle. Go to WAIT.
- WAIT: hold cmdDv=0 and keep cmdStart* stable. On im2colDone:
  - if x+S+K <= W: x+=S, go to ISSUE;
  - else if y+S+K <= H: x=0, y+=S, go to ISSUE;
  - else go to DONE.
- DONE: frameDone=1 for one cycle, busy=0, go to IDLE. winCnt holds until the next accepted start.
- Latency: start at cycle t gives first cmdDv at t+1. im2colDone at cycle n gives the next cmdDv at n+1, or frameDone at n+1.
- Ignored events: start while busy; im2colDone in IDLE, ISSUE or DONE. Ignoring im2colDone in ISSUE means it cannot coincide with its own command.
- Arithmetic: comparisons use XW+2 / YW+2 bit widths, so no wrap occurs at W=NUM_RAM or H=RAM_DEPTH.
- Column order is raster: x fastest, then y.
- Stable inputs: the config inputs only need to be stable on the start cycle.

Optional Feature:
- Macro: IM2COL_SCHED_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and clears on entry to WAIT.
  - If it reaches TIMEOUT_CYC without im2colDone, timeoutErr is set (sticky until rst), busy drops, and the FSM returns to IDLE with no frameDone.
  - A start while timeoutErr=1 is still accepted.
- Undefined: no counter is built and timeoutErr is constant 0.

Test Plan:
- W=4, H=4, kerWidth=2, stride=1, im2colDone 3 cycles after each cmdDv:
  - commands (x,y) = (0,0), (1,0), (0,1), (1,1);
  - frameDone one cycle after the 4th done; winCnt=4.
- W=8, H=3, kerWidth=1, stride=3:
  - commands (0,0), (3,0), (6,0), then frameDone; winCnt=3.
  - Repeat with stride=0: 14 commands (x 0..6, y 0..1).
- kerWidth=3 with W=3, and separately H=2:
  - cfgErr pulses one cycle after start;
  - busy stays 0; no cmdDv.
- Ignored events:
  - start asserted in WAIT: no effect on the sequence;
  - im2colDone asserted in IDLE: no cmdDv;
  - im2colDone on the same cycle as cmdDv: ignored, FSM waits for the next done.
- rst asserted in WAIT after 2 windows:
  - all outputs 0 the next cycle;
  - a new start with W=2, H=2, kerWidth=1 yields one command (0,0) and frameDone; winCnt=1.
- With IM2COL_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16, im2colDone withheld:
  - timeoutErr=1 and busy=0 after 16 WAIT cycles; no frameDone;
  - timeoutErr stays 1 through a following normal frame until rst.

Source files
------------

// File: rtl/im2col_window_scheduler.sv
// Kernel-window command scheduler for the im2col address stage.
// Walks the window origin across one image tile and issues one command per window.
// Ports: clk, rst (sync, active-high), start, imgWidth, imgHeight, kerWidth, stride,
//   im2colDone in; cmdKerWidth, cmdStartX, cmdStartY, cmdDv, busy, frameDone,
//   cfgErr, winCnt, timeoutErr out.
// Optional macro IM2COL_SCHED_TIMEOUT_EN builds the WAIT-state watchdog.
module im2col_window_scheduler #(
  parameter int NUM_RAM     = 8,
  parameter int RAM_DEPTH   = 32,
  parameter int MAX_KER     = 4,
  parameter int TIMEOUT_CYC = 255,
  localparam int XW = $clog2(NUM_RAM),
  localparam int YW = $clog2(RAM_DEPTH),
  localparam int KW = $clog2(MAX_KER)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XW:0]      imgWidth,
  input  logic [YW:0]      imgHeight,
  input  logic [KW-1:0]    kerWidth,
  input  logic [KW-1:0]    stride,
  input  logic             im2colDone,
  output logic [KW-1:0]    cmdKerWidth,
  output logic [XW-1:0]    cmdStartX,
  output logic [YW-1:0]    cmdStartY,
  output logic             cmdDv,
  output logic             busy,
  output logic             frameDone,
  output logic             cfgErr,
  output logic [XW+YW:0]   winCnt,
  output logic             timeoutErr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [KW:0]     r_k;
  logic [KW-1:0]   r_s;
  logic [KW-1:0]   r_ker;
  logic [XW:0]     r_w;
  logic [YW:0]     r_h;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [XW+YW:0]  r_cnt;
  logic            r_cfgErr;

  logic [KW:0]     w_k;
  logic [KW-1:0]   w_s;
  logic            w_bad;
  logic            w_accept;
  logic [XW+1:0]   w_xSum;
  logic [YW+1:0]   w_ySum;
  logic            w_xFit;
  logic            w_yFit;
  logic            w_toHit;

  assign w_k = {1'b0, kerWidth} + (KW+1)'(1);
  assign w_s = (stride == '0) ? KW'(1) : stride;

  // Widened by one bit so K == NUM_RAM / RAM_DEPTH compares without wrap.
  assign w_bad = (imgWidth == '0) || (imgHeight == '0)
              || ((XW+2)'(w_k) > (XW+2)'(imgWidth))
              || ((YW+2)'(w_k) > (YW+2)'(imgHeight));
  assign w_accept = (r_state == S_IDLE) && start && !w_bad;

  assign w_xSum = (XW+2)'(r_x) + (XW+2)'(r_s) + (XW+2)'(r_k);
  assign w_ySum = (YW+2)'(r_y) + (YW+2)'(r_s) + (YW+2)'(r_k);
  assign w_xFit = w_xSum <= (XW+2)'(r_w);
  assign w_yFit = w_ySum <= (YW+2)'(r_h);

`ifdef IM2COL_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_toCnt;
  logic          r_toErr;

  // Fires on the TIMEOUT_CYC-th WAIT cycle that still has no done.
  assign w_toHit = (r_state == S_WAIT) && !im2colDone
                && (r_toCnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_toCnt <= '0;
      r_toErr <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)
        r_toCnt <= '0;
      else if (r_state == S_WAIT)
        r_toCnt <= r_toCnt + TW'(1);
      if (w_toHit)
        r_toErr <= 1'b1;
    end
  end

  assign timeoutErr = r_toErr;
`else
  assign w_toHit    = 1'b0;
  assign timeoutErr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_nxt = S_ISSUE;
      S_ISSUE: w_nxt = S_WAIT;
      S_WAIT: begin
        if (im2colDone)
          w_nxt = (w_xFit || w_yFit) ? S_ISSUE : S_DONE;
        else if (w_toHit)
          w_nxt = S_IDLE;
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k      <= '0;
      r_s      <= '0;
      r_ker    <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_cnt    <= '0;
      r_cfgErr <= 1'b0;
    end else begin
      r_cfgErr <= (r_state == S_IDLE) && start && w_bad;
      if (w_accept) begin
        r_k   <= w_k;
        r_s   <= w_s;
        r_ker <= kerWidth;
        r_w   <= imgWidth;
        r_h   <= imgHeight;
        r_x   <= '0;
        r_y   <= '0;
        r_cnt <= '0;
      end
      if (r_state == S_ISSUE)
        r_cnt <= r_cnt + (XW+YW+1)'(1);
      // Raster walk: step x first, wrap to the next row band.
      if ((r_state == S_WAIT) && im2colDone) begin
        if (w_xFit) begin
          r_x <= r_x + XW'(r_s);
        end else if (w_yFit) begin
          r_x <= '0;
          r_y <= r_y + YW'(r_s);
        end
      end
    end
  end

  assign cmdDv       = (r_state == S_ISSUE);
  assign busy        = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign frameDone   = (r_state == S_DONE);
  assign cfgErr      = r_cfgErr;
  assign cmdKerWidth = r_ker;
  assign cmdStartX   = r_x;
  assign cmdStartY   = r_y;
  assign winCnt      = r_cnt;

endmodule

// File: tb/tb_im2col_window_scheduler.sv
// Scoreboard bench for im2col_window_scheduler.
// Stimulus pushes expected events; a negedge monitor pops and compares.
module tb_im2col_window_scheduler;
  localparam int XW = 3;
  localparam int YW = 5;
  localparam int KW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [XW:0]   imgWidth = '0;
  logic [YW:0]   imgHeight = '0;
  logic [KW-1:0] kerWidth = '0;
  logic [KW-1:0] stride = '0;
  logic          im2colDone = 1'b0;
  logic [KW-1:0] cmdKerWidth;
  logic [XW-1:0] cmdStartX;
  logic [YW-1:0] cmdStartY;
  logic          cmdDv;
  logic          busy;
  logic          frameDone;
  logic          cfgErr;
  logic [XW+YW:0] winCnt;
  logic          timeoutErr;

  im2col_window_scheduler #(
    .NUM_RAM(8), .RAM_DEPTH(32), .MAX_KER(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .imgWidth(imgWidth), .imgHeight(imgHeight),
    .kerWidth(kerWidth), .stride(stride),
    .im2colDone(im2colDone),
    .cmdKerWidth(cmdKerWidth), .cmdStartX(cmdStartX),
    .cmdStartY(cmdStartY), .cmdDv(cmdDv), .busy(busy),
    .frameDone(frameDone), .cfgErr(cfgErr),
    .winCnt(winCnt), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int x;
    int y;
    int k;
    int cnt;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_cmd(int x, int y, int k);
    q.push_back('{0, x, y, k, 0});
  endtask
  task automatic push_done(int cnt);
    q.push_back('{1, 0, 0, 0, cnt});
  endtask
  task automatic push_err();
    q.push_back('{2, 0, 0, 0, 0});
  endtask

  task automatic mon(int kind, int x, int y, int k, int cnt);
    exp_t e;
    if (q.size() == 0) begin
      chk("unexpected event kind", kind, -1);
      return;
    end
    e = q.pop_front();
    chk("event kind", kind, e.kind);
    if (kind == 0 && e.kind == 0) begin
      chk("cmdStartX", x, e.x);
      chk("cmdStartY", y, e.y);
      chk("cmdKerWidth", k, e.k);
    end
    if (kind == 1 && e.kind == 1)
      chk("winCnt at frameDone", cnt, e.cnt);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cmdDv)
        mon(0, int'(cmdStartX), int'(cmdStartY), int'(cmdKerWidth), 0);
      if (frameDone)
        mon(1, 0, 0, 0, int'(winCnt));
      if (cfgErr)
        mon(2, 0, 0, 0, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(int w, int h, int k, int s, bit accept);
    imgWidth  = (XW+1)'(w);
    imgHeight = (YW+1)'(h);
    kerWidth  = KW'(k);
    stride    = KW'(s);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (accept) begin
      chk("first cmd latency", int'(cmdDv), 1);
    end else begin
      chk("cfgErr after bad start", int'(cfgErr), 1);
      chk("busy after bad start", int'(busy), 0);
      tick();
      chk("cfgErr one cycle", int'(cfgErr), 0);
      chk("no cmd after bad start", int'(cmdDv), 0);
    end
  endtask

  task automatic serve(int delay, bit inj);
    for (int w = 0; w < 64; w++) begin
      if (!cmdDv) begin
        chk("cmdDv expected", int'(cmdDv), 1);
        return;
      end
      for (int i = 0; i < delay; i++) begin
        if (inj && w == 0 && i == 1) begin
          start = 1'b1;
          imgWidth = 4'd8;
        end
        tick();
        start = 1'b0;
      end
      im2colDone = 1'b1;
      tick();
      im2colDone = 1'b0;
      chk("done to next latency", int'(cmdDv | frameDone), 1);
      if (frameDone) begin
        tick();
        return;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("reset outputs", int'({cmdDv, busy, frameDone, cfgErr, timeoutErr,
        winCnt, cmdStartX, cmdStartY, cmdKerWidth}), 0);
    rst = 1'b0;
    tick();

    // 4x4 tile, 3x3 kernel, stride 1, start injected during WAIT
    push_cmd(0, 0, 2); push_cmd(1, 0, 2);
    push_cmd(0, 1, 2); push_cmd(1, 1, 2);
    push_done(4);
    start_frame(4, 4, 2, 1, 1);
    serve(3, 1);
    chk("busy after frame", int'(busy), 0);
    chk("winCnt holds", int'(winCnt), 4);

    // 8x3, 2x2 kernel, stride 3
    push_cmd(0, 0, 1); push_cmd(3, 0, 1); push_cmd(6, 0, 1);
    push_done(3);
    start_frame(8, 3, 1, 3, 1);
    serve(3, 0);

    // stride 0 behaves as 1
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 7; x++)
        push_cmd(x, y, 1);
    push_done(14);
    start_frame(8, 3, 1, 0, 1);
    serve(2, 0);

    // rejected configs
    push_err();
    start_frame(3, 4, 3, 1, 0);
    push_err();
    start_frame(8, 2, 3, 1, 0);

    // done in IDLE is ignored
    im2colDone = 1'b1;
    tick();
    im2colDone = 1'b0;
    chk("no cmd on idle done", int'(cmdDv), 0);
    chk("idle stays idle", int'(busy), 0);
    tick();

    // done coinciding with cmdDv is ignored
    push_cmd(0, 0, 1);
    push_done(1);
    start_frame(2, 2, 1, 1, 1);
    im2colDone = 1'b1;
    tick();
    im2colDone = 1'b0;
    chk("busy after ISSUE done", int'(busy), 1);
    tick();
    chk("no early frameDone", int'(frameDone), 0);
    chk("no extra cmd", int'(cmdDv), 0);
    im2colDone = 1'b1;
    tick();
    im2colDone = 1'b0;
    chk("frameDone after real done", int'(frameDone), 1);
    tick();

    // reset mid-frame
    push_cmd(0, 0, 1); push_cmd(3, 0, 1);
    start_frame(8, 3, 1, 3, 1);
    repeat (3) tick();
    im2colDone = 1'b1;
    tick();
    im2colDone = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("outputs after rst", int'({cmdDv, busy, frameDone, cfgErr, timeoutErr,
        winCnt, cmdStartX, cmdStartY, cmdKerWidth}), 0);
    push_cmd(0, 0, 1);
    push_done(1);
    start_frame(2, 2, 1, 1, 1);
    serve(3, 0);

`ifdef IM2COL_SCHED_TIMEOUT_EN
    push_cmd(0, 0, 1);
    start_frame(2, 2, 1, 1, 1);
    repeat (16) tick();
    chk("no timeout yet", int'(timeoutErr), 0);
    chk("busy before timeout", int'(busy), 1);
    tick();
    chk("timeoutErr set", int'(timeoutErr), 1);
    chk("busy after timeout", int'(busy), 0);
    chk("no frameDone on timeout", int'(frameDone), 0);
    tick();
    push_cmd(0, 0, 1);
    push_done(1);
    start_frame(2, 2, 1, 1, 1);
    serve(3, 0);
    chk("timeoutErr sticky", int'(timeoutErr), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("timeoutErr cleared", int'(timeoutErr), 0);
`endif

    repeat (3) tick();
    chk("scoreboard drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
